// File: rtl/babylonian_sqrt_ctrl_if.sv
// Handshake bundle for babylonian_sqrt_ctrl: front-end start/result signals
// plus the request/response pair toward the shared divider.
interface babylonian_sqrt_ctrl_if;
  logic        start;
  logic [23:0] num;
  logic        busy;
  logic        done;
  logic [11:0] root;
  logic [3:0]  iters;
  logic        err;
  logic        div_req;
  logic [23:0] div_dividend;
  logic [11:0] div_divisor;
  logic        div_done;
  logic [23:0] div_quot;

  // The controller side.
  modport slave (
    input  start, num, div_done, div_quot,
    output busy, done, root, iters, err, div_req, div_dividend, div_divisor
  );

  // The environment side: sqrt front end plus divider.
  modport master (
    output start, num, div_done, div_quot,
    input  busy, done, root, iters, err, div_req, div_dividend, div_divisor
  );
endinterface

// File: rtl/babylonian_sqrt_ctrl.sv
// Newton/Babylonian square-root sequencer: Q16.8 radicand in, Q8.4 root out.
// Optional divider watchdog enabled by defining SQRT_CTRL_DIV_TIMEOUT_EN.
module babylonian_sqrt_ctrl #(
  parameter int unsigned MAX_ITER    = 8,
  parameter int unsigned DIV_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  babylonian_sqrt_ctrl_if.slave bus
);

  if (MAX_ITER < 1 || MAX_ITER > 15 || DIV_TIMEOUT < 1) begin : g_param_check
    $error("babylonian_sqrt_ctrl: MAX_ITER must be 1..15 and DIV_TIMEOUT >= 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_DIV, S_UPDATE, S_DONE} state_t;

  state_t      r_state;
  logic [23:0] r_num;
  logic [11:0] r_x;
  logic [23:0] r_quot;
  logic [3:0]  r_count;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic        r_div_req;
  logic [11:0] r_root;
  logic [3:0]  r_iters;

`ifdef SQRT_CTRL_DIV_TIMEOUT_EN
  localparam int unsigned TW = $clog2(DIV_TIMEOUT + 1);
  logic [TW-1:0] r_tmo;
`endif

  logic [4:0]  w_msb;
  logic [4:0]  w_shift;
  logic [11:0] w_x0;
  logic [24:0] w_sum;
  logic [24:0] w_half;
  logic [11:0] w_xn;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_msb = '0;
    for (int i = 0; i < 24; i++) begin
      if (r_num[i]) w_msb = 5'(i);
    end
  end

  // Power-of-two seed at or above the true root; 1 << 12 does not fit in Q8.4.
  assign w_shift = (w_msb >> 1) + 5'd1;
  assign w_x0    = (w_shift >= 5'd12) ? 12'hFFF : (12'd1 << w_shift);

  assign w_sum  = {13'd0, r_x} + {1'b0, r_quot};
  assign w_half = w_sum >> 1;
  assign w_xn   = (w_half > 25'hFFF) ? 12'hFFF : w_half[11:0];

  // NOTE: state is updated with non-blocking assignments so every register
  // sees the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_num     <= '0;
      r_x       <= '0;
      r_quot    <= '0;
      r_count   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_div_req <= 1'b0;
      r_root    <= '0;
      r_iters   <= '0;
`ifdef SQRT_CTRL_DIV_TIMEOUT_EN
      r_tmo     <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_num   <= bus.num;
            r_count <= '0;
            r_busy  <= 1'b1;
            r_state <= S_INIT;
          end
        end
        S_INIT: begin
          if (r_num == 24'd0) begin
            r_root  <= '0;
            r_iters <= '0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_x       <= w_x0;
            r_div_req <= 1'b1;
`ifdef SQRT_CTRL_DIV_TIMEOUT_EN
            r_tmo     <= '0;
`endif
            r_state   <= S_DIV;
          end
        end
        S_DIV: begin
          if (bus.div_done) begin
            r_quot    <= bus.div_quot;
            r_count   <= r_count + 4'd1;
            r_div_req <= 1'b0;
            r_state   <= S_UPDATE;
          end
`ifdef SQRT_CTRL_DIV_TIMEOUT_EN
          else if (r_tmo == TW'(DIV_TIMEOUT - 1)) begin
            r_div_req <= 1'b0;
            r_err     <= 1'b1;
            r_root    <= 12'hFFF;
            r_iters   <= r_count;
            r_state   <= S_DONE;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
`endif
        end
        S_UPDATE: begin
          // A non-decreasing step means the sequence has bottomed out.
          if (w_xn >= r_x) begin
            r_root  <= r_x;
            r_iters <= r_count;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (r_count == 4'(MAX_ITER)) begin
            r_root  <= w_xn;
            r_iters <= r_count;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_x       <= w_xn;
            r_div_req <= 1'b1;
`ifdef SQRT_CTRL_DIV_TIMEOUT_EN
            r_tmo     <= '0;
`endif
            r_state   <= S_DIV;
          end
        end
        S_DONE: begin
          // After a timeout, err occupies this cycle and done follows it.
          if (r_err) begin
            r_done <= 1'b1;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.err          = r_err;
  assign bus.root         = r_root;
  assign bus.iters        = r_iters;
  assign bus.div_req      = r_div_req;
  assign bus.div_dividend = r_num;
  assign bus.div_divisor  = r_x;

endmodule
